// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive framing (start detect, LSB-first shift, parity/stop check, one-deep valid/ready holding register, sticky errors)
// pclk/preset: clock and synchronous active-high reset
// rxd_sync/sample_edge: synchronized RX line and bit-centre strobe from the baud sampler
// baud_restart: realigns the baud sampler on a start edge
// rx_data/rx_valid/rx_ready: received word handshake
// framing_err/parity_err/overrun_err/err_clear: sticky error flags and their clear
// busy: a frame is in progress
module uart_rx_frame_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 rxd_sync,
    input  logic                 sample_edge,
    output logic                 baud_restart,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    input  logic                 err_clear,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               r_state, w_next;
    logic                 r_rxd_prev;
    logic [DATA_BITS-1:0] r_shreg;
    logic [2:0]           r_bit_cnt;
    logic                 r_par_bad;
    logic                 w_fall, w_last, w_done, w_load;
    assign w_fall = r_rxd_prev && !rxd_sync;
    assign w_last = r_bit_cnt == 3'(DATA_BITS - 1);
    assign w_done = r_state == STOP && sample_edge;
    // a completing frame lands in the holding register only if it is empty or being drained this cycle
    assign w_load = w_done && (!rx_valid || rx_ready);
    always_comb begin
        w_next       = r_state;
        baud_restart = 1'b0;
        busy         = r_state != IDLE;
        case (r_state)
            IDLE: begin
                baud_restart = w_fall;
                w_next       = w_fall ? START : IDLE;
            end
            START:   w_next = sample_edge ? (rxd_sync ? IDLE : DATA) : START;
            DATA:    w_next = (sample_edge && w_last) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
            PARITY:  w_next = sample_edge ? STOP : PARITY;
            STOP:    w_next = sample_edge ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_rxd_prev  <= 1'b1;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_par_bad   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rxd_prev <= rxd_sync;
            if (r_state == START && sample_edge && !rxd_sync)
                r_bit_cnt <= '0;
            if (r_state == DATA && sample_edge) begin
                r_shreg   <= {rxd_sync, r_shreg[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == PARITY && sample_edge)
                r_par_bad <= ^{r_shreg, rxd_sync} ^ 1'(PARITY_ODD);
            if (w_load) begin
                rx_data  <= r_shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            framing_err <= err_clear ? 1'b0 : framing_err || (w_done && !rxd_sync);
            parity_err  <= err_clear ? 1'b0 : parity_err || (w_done && r_par_bad && PARITY_EN != 0);
            overrun_err <= err_clear ? 1'b0 : overrun_err || (w_done && rx_valid && !rx_ready);
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: three configurations (8N1, 8E1, 5O1) driven frame by frame against a transaction-level model
module tb_uart_rx_frame_ctrl;
    localparam int NC = 3;
    logic clk = 1'b0;
    logic preset = 1'b1;
    logic chk_en = 1'b0;
    logic rnd = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic rxd[NC], se[NC], rdy[NC], clr[NC];
    logic br[NC], rv[NC], fe[NC], pe_o[NC], oe[NC], bz[NC];
    logic [7:0] rd0, rd1;
    logic [4:0] rd2;
    logic ev_st[NC], ev_end[NC], ev_cmp[NC], ev_stop[NC], ev_pb[NC];
    logic [7:0] ev_d[NC];
    logic m_v[NC], m_fe[NC], m_pe[NC], m_oe[NC], m_bz[NC];
    logic [7:0] m_d[NC];

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .pclk(clk), .preset(preset), .rxd_sync(rxd[0]), .sample_edge(se[0]), .baud_restart(br[0]),
        .rx_data(rd0), .rx_valid(rv[0]), .rx_ready(rdy[0]), .framing_err(fe[0]), .parity_err(pe_o[0]),
        .overrun_err(oe[0]), .err_clear(clr[0]), .busy(bz[0]));
    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .pclk(clk), .preset(preset), .rxd_sync(rxd[1]), .sample_edge(se[1]), .baud_restart(br[1]),
        .rx_data(rd1), .rx_valid(rv[1]), .rx_ready(rdy[1]), .framing_err(fe[1]), .parity_err(pe_o[1]),
        .overrun_err(oe[1]), .err_clear(clr[1]), .busy(bz[1]));
    uart_rx_frame_ctrl #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .pclk(clk), .preset(preset), .rxd_sync(rxd[2]), .sample_edge(se[2]), .baud_restart(br[2]),
        .rx_data(rd2), .rx_valid(rv[2]), .rx_ready(rdy[2]), .framing_err(fe[2]), .parity_err(pe_o[2]),
        .overrun_err(oe[2]), .err_clear(clr[2]), .busy(bz[2]));

    function automatic int db(input int c);
        return c == 2 ? 5 : 8;
    endfunction
    function automatic logic has_par(input int c);
        return c != 0;
    endfunction
    function automatic logic odd(input int c);
        return c == 2;
    endfunction
    function automatic logic [7:0] rdv(input int c);
        return c == 0 ? rd0 : c == 1 ? rd1 : {3'b000, rd2};
    endfunction

    task automatic chk(input string nm, input int c, input logic [7:0] a, input logic [7:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s ch%0d got=%h exp=%h t=%0t", nm, c, a, e, $time);
        end
    endtask

    // Model: what a completed frame does to the holding register and flags, plus frame-level busy
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (preset) begin
                m_v[c] <= 1'b0; m_d[c] <= 8'h00; m_fe[c] <= 1'b0;
                m_pe[c] <= 1'b0; m_oe[c] <= 1'b0; m_bz[c] <= 1'b0;
            end else begin
                if (ev_cmp[c] && (!m_v[c] || rdy[c])) begin
                    m_v[c] <= 1'b1;
                    m_d[c] <= ev_d[c];
                end else if (m_v[c] && rdy[c]) begin
                    m_v[c] <= 1'b0;
                end
                m_fe[c] <= clr[c] ? 1'b0 : m_fe[c] | (ev_cmp[c] & ~ev_stop[c]);
                m_pe[c] <= clr[c] ? 1'b0 : m_pe[c] | (ev_cmp[c] & ev_pb[c]);
                m_oe[c] <= clr[c] ? 1'b0 : m_oe[c] | (ev_cmp[c] & m_v[c] & ~rdy[c]);
                m_bz[c] <= ev_st[c] ? 1'b1 : ev_end[c] ? 1'b0 : m_bz[c];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NC; c++) begin
                chk("baud_restart", c, 8'(br[c]), 8'(ev_st[c]));
                chk("rx_valid", c, 8'(rv[c]), 8'(m_v[c]));
                chk("rx_data", c, rdv(c), m_d[c]);
                chk("framing_err", c, 8'(fe[c]), 8'(m_fe[c]));
                chk("parity_err", c, 8'(pe_o[c]), 8'(m_pe[c]));
                chk("overrun_err", c, 8'(oe[c]), 8'(m_oe[c]));
                chk("busy", c, 8'(bz[c]), 8'(m_bz[c]));
            end
        end
    end

    task automatic cyc(input int c, input logic r, input logic s, input logic st, input logic en, input logic cm);
        rxd[c] = r; se[c] = s; ev_st[c] = st; ev_end[c] = en; ev_cmp[c] = cm;
        if (rnd) begin
            rdy[c] = 1'($urandom_range(0, 1));
            clr[c] = $urandom_range(0, 19) == 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gaps(input int c, input logic v, input int maxgap);
        repeat ($urandom_range(0, maxgap)) cyc(c, v, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int c, input int n);
        repeat (n) cyc(c, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int c, input logic [7:0] d, input logic stopb, input logic parb, input int maxgap);
        logic [7:0] dm;
        dm = d & 8'((1 << db(c)) - 1);
        cyc(c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        gaps(c, 1'b0, maxgap);
        cyc(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < db(c); i++) begin
            gaps(c, dm[i], maxgap);
            cyc(c, dm[i], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (has_par(c)) begin
            gaps(c, parb, maxgap);
            cyc(c, parb, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        ev_d[c] = dm;
        ev_stop[c] = stopb;
        ev_pb[c] = has_par(c) && ((^dm) ^ parb ^ odd(c));
        gaps(c, stopb, maxgap);
        cyc(c, stopb, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic false_start(input int c, input int lowc);
        cyc(c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (lowc - 1) cyc(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(c, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            rxd[c] = 1'b1; se[c] = 1'b0; rdy[c] = 1'b1; clr[c] = 1'b0;
            ev_st[c] = 1'b0; ev_end[c] = 1'b0; ev_cmp[c] = 1'b0; ev_stop[c] = 1'b1; ev_pb[c] = 1'b0; ev_d[c] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        preset = 1'b0;
        chk_en = 1'b1;
        chk("reset_valid", 0, 8'(rv[0]), 8'h00);
        chk("reset_data", 0, rd0, 8'h00);
        chk("reset_busy", 0, 8'(bz[0]), 8'h00);
        idle(0, 2);
        frame(0, 8'hA5, 1'b1, 1'b0, 2);
        chk("a5_valid", 0, 8'(rv[0]), 8'h01);
        chk("a5_data", 0, rd0, 8'hA5);
        chk("a5_flags", 0, {5'b0, fe[0], pe_o[0], oe[0]}, 8'h00);
        idle(0, 1);
        chk("a5_pulse_end", 0, 8'(rv[0]), 8'h00);
        idle(0, 2);
        false_start(0, 3);
        chk("false_start_valid", 0, 8'(rv[0]), 8'h00);
        chk("false_start_busy", 0, 8'(bz[0]), 8'h00);
        idle(0, 2);
        frame(0, 8'h3C, 1'b0, 1'b0, 1);
        chk("3c_data", 0, rd0, 8'h3C);
        chk("3c_valid", 0, 8'(rv[0]), 8'h01);
        chk("3c_framing", 0, 8'(fe[0]), 8'h01);
        idle(0, 1);
        clr[0] = 1'b1;
        idle(0, 1);
        clr[0] = 1'b0;
        chk("3c_cleared", 0, 8'(fe[0]), 8'h00);
        idle(1, 2);
        frame(1, 8'h07, 1'b1, 1'b0, 1);
        chk("07_par0_err", 1, 8'(pe_o[1]), 8'h01);
        idle(1, 1);
        clr[1] = 1'b1;
        idle(1, 1);
        clr[1] = 1'b0;
        frame(1, 8'h07, 1'b1, 1'b1, 1);
        chk("07_par1_err", 1, 8'(pe_o[1]), 8'h00);
        chk("07_data", 1, rd1, 8'h07);
        idle(1, 2);
        rdy[0] = 1'b0;
        frame(0, 8'h11, 1'b1, 1'b0, 1);
        idle(0, 2);
        frame(0, 8'h22, 1'b1, 1'b0, 1);
        chk("ovr_data", 0, rd0, 8'h11);
        chk("ovr_flag", 0, 8'(oe[0]), 8'h01);
        chk("ovr_valid", 0, 8'(rv[0]), 8'h01);
        idle(0, 1);
        rdy[0] = 1'b1;
        clr[0] = 1'b1;
        idle(0, 1);
        clr[0] = 1'b0;
        idle(0, 2);
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 1'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        preset = 1'b1;
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        preset = 1'b0;
        chk("reset_mid_busy", 0, 8'(bz[0]), 8'h00);
        chk("reset_mid_valid", 0, 8'(rv[0]), 8'h00);
        idle(0, 2);
        frame(0, 8'h5A, 1'b1, 1'b0, 2);
        chk("5a_data", 0, rd0, 8'h5A);
        chk("5a_valid", 0, 8'(rv[0]), 8'h01);
        idle(0, 2);
        frame(2, 8'h13, 1'b1, 1'b0, 1);
        chk("5o1_data", 2, rdv(2), 8'h13);
        chk("5o1_par", 2, 8'(pe_o[2]), 8'h00);
        idle(2, 2);
        rnd = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int c;
            c = $urandom_range(0, NC - 1);
            if ($urandom_range(0, 9) == 0) false_start(c, $urandom_range(1, 4));
            else frame(c, 8'($urandom), $urandom_range(0, 6) != 0, 1'($urandom_range(0, 1)), 3);
            idle(c, $urandom_range(1, 3));
        end
        rnd = 1'b0;
        for (int c = 0; c < NC; c++) begin
            rdy[c] = 1'b1;
            clr[c] = 1'b0;
        end
        idle(0, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
